// File: rtl/yarvi_ls_issue_pkg.sv
// Shared types for the load/store issue unit.
// Widths are taken from the common yarvi width definitions.
// The queued request is stored as one packed struct.
`define VMSB 31
`define XMSB 31

package yarvi_ls_issue_pkg;

    localparam int VLEN = `VMSB + 1;
    localparam int XLEN = `XMSB + 1;

    localparam logic [1:0] LS_SIZE_B = 2'd0;
    localparam logic [1:0] LS_SIZE_H = 2'd1;
    localparam logic [1:0] LS_SIZE_W = 2'd2;
    localparam logic [1:0] LS_SIZE_D = 2'd3;

    typedef struct packed {
        logic            store;
        logic [VLEN-1:0] address;
        logic [XLEN-1:0] data;
        logic [1:0]      sizelg2;
        logic [4:0]      rd;
        logic            signextend;
    } ls_req_t;

    // Loads to x0 are issued but never tracked in the scoreboard.
    function automatic logic tracked_load(input ls_req_t r);
        return !r.store && (r.rd != 5'd0);
    endfunction
endpackage

// File: rtl/yarvi_ls_issue_if.sv
// Execute, memory request/response and writeback signals of the issue unit.
// master: the issue unit; slave: its environment (execute + memory unit).
// Pure wiring, no state.
interface yarvi_ls_issue_if;
    import yarvi_ls_issue_pkg::*;

    logic            ex_valid;
    logic            ex_ready;
    logic            ex_store;
    logic [VLEN-1:0] ex_address;
    logic [XLEN-1:0] ex_data;
    logic [1:0]      ex_sizelg2;
    logic [4:0]      ex_rd;
    logic            ex_signextend;
    logic            flush;

    logic            mem_valid;
    logic            mem_writeenable;
    logic [VLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_writedata;
    logic [1:0]      mem_sizelg2;
    logic [4:0]      mem_readtag;
    logic            mem_readsignextend;
    logic            me_ready;

    logic            me_readdatavalid;
    logic [4:0]      me_readdatatag;
    logic [XLEN-1:0] me_readdata;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     busy;
    logic            tag_error;

    modport master (
        input  ex_valid, ex_store, ex_address, ex_data, ex_sizelg2, ex_rd,
               ex_signextend, flush, me_ready, me_readdatavalid,
               me_readdatatag, me_readdata,
        output ex_ready, mem_valid, mem_writeenable, mem_address,
               mem_writedata, mem_sizelg2, mem_readtag, mem_readsignextend,
               wb_valid, wb_rd, wb_data, busy, tag_error
    );

    modport slave (
        output ex_valid, ex_store, ex_address, ex_data, ex_sizelg2, ex_rd,
               ex_signextend, flush, me_ready, me_readdatavalid,
               me_readdatatag, me_readdata,
        input  ex_ready, mem_valid, mem_writeenable, mem_address,
               mem_writedata, mem_sizelg2, mem_readtag, mem_readsignextend,
               wb_valid, wb_rd, wb_data, busy, tag_error
    );
endinterface

// File: rtl/yarvi_ls_fifo.sv
// In-order request queue with synchronous clear; head is read combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: full is based on the registered count only (no pop bypass).
module yarvi_ls_fifo
    import yarvi_ls_issue_pkg::*;
#(
    parameter int DEPTH = 4  // power of two, at least 2
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    clear,
    input  logic    push,
    input  ls_req_t push_data,
    input  logic    pop,
    output ls_req_t head,
    output logic    full,
    output logic    empty
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    ls_req_t       slots [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = slots[rd_ptr];

    // Storage needs no reset: only slots below the count are ever observed.
    always_ff @(posedge clock) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
            else if (!do_push && do_pop) count <= count - (AW + 1)'(1);
        end
    end
endmodule

// File: rtl/yarvi_ls_issue.sv
// Load/store issue: queues execute requests, issues in order, tracks outstanding loads.
// Latency: enqueue->mem_valid 1 cycle; read response->writeback 1 cycle.
// Backpressure: ex_ready = !full; head stalls on !me_ready or a WAW busy hit on its rd.
module yarvi_ls_issue
    import yarvi_ls_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    yarvi_ls_issue_if.master ls
);
    ls_req_t         enq_req;
    ls_req_t         head;
    logic            full;
    logic            empty;
    logic            push;
    logic            hazard;
    logic            issue;
    logic            resp_hit;
    logic [31:0]     busy_q;
    logic [31:0]     busy_nxt;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            tag_error_q;

    assign enq_req = '{store:      ls.ex_store,
                       address:    ls.ex_address,
                       data:       ls.ex_data,
                       sizelg2:    ls.ex_sizelg2,
                       rd:         ls.ex_rd,
                       signextend: ls.ex_signextend};

    assign push   = ls.ex_valid && !full && !ls.flush;
    // Registered busy only: a load waiting on its own rd issues the cycle after the clear.
    assign hazard = tracked_load(head) && busy_q[head.rd];
    assign issue  = ls.mem_valid && ls.me_ready;

    yarvi_ls_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (ls.flush),
        .push      (push),
        .push_data (enq_req),
        .pop       (issue),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign ls.ex_ready           = !full;
    assign ls.mem_valid          = !empty && !hazard && !ls.flush;
    assign ls.mem_writeenable    = head.store;
    assign ls.mem_address        = head.address;
    assign ls.mem_writedata      = head.data;
    assign ls.mem_sizelg2        = head.sizelg2;
    assign ls.mem_readtag        = head.rd;
    assign ls.mem_readsignextend = head.signextend;

    assign resp_hit = ls.me_readdatavalid && (ls.me_readdatatag != 5'd0);

    // Scoreboard next state: response clears, load issue sets; set applied last so it wins.
    always_comb begin
        busy_nxt = busy_q;
        if (resp_hit) busy_nxt[ls.me_readdatatag] = 1'b0;
        if (issue && tracked_load(head)) busy_nxt[head.rd] = 1'b1;
    end

    // Scoreboard register; flush deliberately leaves it alone so in-flight loads retire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_nxt;
    end

    // Writeback register and sticky tag error for responses to untracked registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            tag_error_q <= 1'b0;
        end else begin
            wb_valid_q <= resp_hit;
            if (ls.me_readdatavalid) begin
                wb_rd_q   <= ls.me_readdatatag;
                wb_data_q <= ls.me_readdata;
            end
            if (resp_hit && !busy_q[ls.me_readdatatag]) tag_error_q <= 1'b1;
        end
    end

    assign ls.busy      = busy_q;
    assign ls.wb_valid  = wb_valid_q;
    assign ls.wb_rd     = wb_rd_q;
    assign ls.wb_data   = wb_data_q;
    assign ls.tag_error = tag_error_q;
endmodule

// File: tb/tb_yarvi_ls_issue.sv
// Randomized scoreboard bench for yarvi_ls_issue.
// Stimulus drives just after posedge; the monitor samples at negedge.
// Expected issues, busy bits and writebacks come from a queue-level model.
module tb_yarvi_ls_issue;
    import yarvi_ls_issue_pkg::*;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    yarvi_ls_issue_if bus ();

    yarvi_ls_issue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .ls    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit run         = 1'b0;

    // Reference model state.
    ls_req_t              model_q[$];
    logic [31:0]          model_busy = '0;
    logic                 model_te   = 1'b0;
    int                   outstanding[$];
    logic [XLEN+4:0]      exp_wb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model, then advance the model to the next edge.
    always @(negedge clock) begin
        if (run) begin
            ls_req_t     hd;
            ls_req_t     act;
            ls_req_t     nr;
            logic        hz;
            logic        exp_mv;
            logic        accept;
            logic [31:0] nb;
            logic [XLEN+4:0] w;

            hz = 1'b0;
            if (model_q.size() != 0)
                hz = !model_q[0].store && (model_q[0].rd != 5'd0) && model_busy[model_q[0].rd];
            exp_mv = (model_q.size() != 0) && !bus.flush && !hz;
            accept = bus.ex_valid && (model_q.size() < DEPTH) && !bus.flush;

            chk("ex_ready", 128'(bus.ex_ready), 128'(model_q.size() < DEPTH));
            chk("mem_valid", 128'(bus.mem_valid), 128'(exp_mv));
            chk("busy", 128'(bus.busy), 128'(model_busy));
            chk("tag_error", 128'(bus.tag_error), 128'(model_te));

            if (exp_wb.size() != 0) begin
                w = exp_wb.pop_front();
                chk("wb_valid", 128'(bus.wb_valid), 128'(1));
                chk("wb_rd", 128'(bus.wb_rd), 128'(w[XLEN+4:XLEN]));
                chk("wb_data", 128'(bus.wb_data), 128'(w[XLEN-1:0]));
            end else begin
                chk("wb_valid", 128'(bus.wb_valid), 128'(0));
            end

            if (exp_mv) begin
                act.store      = bus.mem_writeenable;
                act.address    = bus.mem_address;
                act.data       = bus.mem_writedata;
                act.sizelg2    = bus.mem_sizelg2;
                act.rd         = bus.mem_readtag;
                act.signextend = bus.mem_readsignextend;
                chk("mem_request", 128'(act), 128'(model_q[0]));
            end

            nb = model_busy;
            if (bus.me_readdatavalid && bus.me_readdatatag != 5'd0) begin
                if (!model_busy[bus.me_readdatatag]) model_te = 1'b1;
                nb[bus.me_readdatatag] = 1'b0;
                exp_wb.push_back({bus.me_readdatatag, bus.me_readdata});
            end

            if (bus.flush) begin
                model_q.delete();
            end else begin
                if (exp_mv && bus.me_ready) begin
                    hd = model_q.pop_front();
                    if (!hd.store && hd.rd != 5'd0) begin
                        nb[hd.rd] = 1'b1;
                        outstanding.push_back(int'(hd.rd));
                    end
                end
                if (accept) begin
                    nr.store      = bus.ex_store;
                    nr.address    = bus.ex_address;
                    nr.data       = bus.ex_data;
                    nr.sizelg2    = bus.ex_sizelg2;
                    nr.rd         = bus.ex_rd;
                    nr.signextend = bus.ex_signextend;
                    model_q.push_back(nr);
                end
            end
            model_busy = nb;
        end
    end

    task automatic idle_inputs();
        bus.ex_valid         = 1'b0;
        bus.ex_store         = 1'b0;
        bus.ex_address       = '0;
        bus.ex_data          = '0;
        bus.ex_sizelg2       = '0;
        bus.ex_rd            = '0;
        bus.ex_signextend    = 1'b0;
        bus.flush            = 1'b0;
        bus.me_ready         = 1'b0;
        bus.me_readdatavalid = 1'b0;
        bus.me_readdatatag   = '0;
        bus.me_readdata      = '0;
    endtask

    task automatic respond_outstanding();
        int idx;
        idx = $urandom_range(0, outstanding.size() - 1);
        bus.me_readdatavalid = 1'b1;
        bus.me_readdatatag   = 5'(outstanding[idx]);
        bus.me_readdata      = XLEN'($urandom);
        outstanding.delete(idx);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ex_ready"}, 128'(bus.ex_ready), 128'(1));
        chk({tag, "_mem_valid"}, 128'(bus.mem_valid), 128'(0));
        chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
        chk({tag, "_wb_valid"}, 128'(bus.wb_valid), 128'(0));
        chk({tag, "_wb_rd"}, 128'(bus.wb_rd), 128'(0));
        chk({tag, "_wb_data"}, 128'(bus.wb_data), 128'(0));
        chk({tag, "_tag_error"}, 128'(bus.tag_error), 128'(0));
    endtask

    initial begin
        int  drain;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state("reset");

        // Random traffic; every fourth 50-cycle window holds me_ready low to fill the queue.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clock);
            #1;
            run                = 1'b1;
            bus.ex_valid       = ($urandom % 4) != 0;
            bus.ex_store       = ($urandom % 2) != 0;
            bus.ex_address     = VLEN'($urandom);
            bus.ex_data        = XLEN'($urandom);
            bus.ex_sizelg2     = 2'($urandom_range(0, 3));
            bus.ex_rd          = (($urandom % 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            bus.ex_signextend  = ($urandom % 2) != 0;
            bus.flush          = ($urandom % 60) == 0;
            bus.me_ready       = (((cyc / 50) % 4) == 1) ? 1'b0 : (($urandom % 4) != 0);
            bus.me_readdatavalid = 1'b0;
            bus.me_readdatatag   = '0;
            bus.me_readdata      = '0;
            if (outstanding.size() != 0 && ($urandom % 3) == 0) begin
                respond_outstanding();
            end else if (($urandom % 40) == 0) begin
                bus.me_readdatavalid = 1'b1;
                bus.me_readdatatag   = 5'd0;
                bus.me_readdata      = XLEN'($urandom);
            end
        end

        // Drain: stop execute, keep memory ready, return every outstanding load.
        drain = 0;
        while ((model_q.size() != 0 || outstanding.size() != 0 || model_busy != 0) && drain < 300) begin
            @(posedge clock);
            #1;
            idle_inputs();
            bus.me_ready = 1'b1;
            if (outstanding.size() != 0) respond_outstanding();
            drain++;
        end
        vectors++;
        if (drain >= 300) begin
            miscompares++;
            $display("FAIL drain_timeout: queue %0d outstanding %0d left, required 0",
                     model_q.size(), outstanding.size());
        end

        // Response for a register that is not busy: writeback still happens, error sticks.
        @(posedge clock);
        #1;
        idle_inputs();
        bus.me_readdatavalid = 1'b1;
        bus.me_readdatatag   = 5'd9;
        bus.me_readdata      = XLEN'(32'hCAFE_0009);
        @(posedge clock);
        #1;
        idle_inputs();
        repeat (5) @(posedge clock);
        #1;
        chk("tag_error_sticky", 128'(bus.tag_error), 128'(1));

        // Mid-operation reset clears everything immediately.
        run   = 1'b0;
        reset = 1'b1;
        model_q.delete();
        outstanding.delete();
        exp_wb.delete();
        model_busy = '0;
        model_te   = 1'b0;
        @(negedge clock);
        check_reset_state("rereset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/yarvi_ls_issue.md
# yarvi_ls_issue

Load/store issue unit: the core-side initiator for the memory unit's request/response interface. It buffers load/store requests from execute in a small in-order queue and presents them one per cycle on the memory request port when the memory unit is ready. It keeps a per-register busy scoreboard for outstanding loads and registers returning read data into a writeback port keyed by destination register.

## Interface
Parameters:
- `DEPTH`, default 4, queue entries; must be a power of two and at least 2.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `ex_valid`  in  1  execute presents a request.
- `ex_ready`  out  1  queue can accept; equals `!full`.
- `ex_store`  in  1  1 = store, 0 = load.
- `ex_address`  in  `VMSB+1  byte address.
- `ex_data`  in  `XMSB+1  store data.
- `ex_sizelg2`  in  2  log2 access bytes.
- `ex_rd`  in  5  load destination register; also used as the read tag.
- `ex_signextend`  in  1  sign-extend load result.
- `flush`  in  1  discard all queued, not-yet-issued entries.
- `mem_valid`, `mem_writeenable`, `mem_address`, `mem_writedata`, `mem_sizelg2`, `mem_readtag`, `mem_readsignextend`  out  1/1/`VMSB+1/`XMSB+1/2/5/1  request to memory unit.
- `me_ready`  in  1  memory unit accepts this cycle.
- `me_readdatavalid`, `me_readdatatag`, `me_readdata`  in  1/5/`XMSB+1  read response.
- `wb_valid`, `wb_rd`, `wb_data`  out  1/5/`XMSB+1  registered load writeback.
- `busy`  out  32  scoreboard; bit r set while a load to r is outstanding.
- `tag_error`  out  1  sticky; response arrived for a non-busy, nonzero tag.

## Operation
- Enqueue when `ex_valid && ex_ready && !flush`. No bypass: a full queue deasserts `ex_ready` even if dequeuing that cycle.
- Head drives all `mem_*` fields combinationally. `mem_readtag` = head rd.
- `mem_valid = !empty && !hazard && !flush`. `hazard` = head is a load with rd≠0 and `busy[rd]` set (WAW stall). `busy` is the registered value; there is no same-cycle clear bypass.
- Issue = `mem_valid && me_ready`. Issue pops the head.
- Load issue with rd≠0 sets `busy[rd]`. Loads to x0 issue but are not tracked.
- A response with tag t≠0 clears `busy[t]`. Set and clear for the same bit cannot coincide because of the hazard stall; if they did, set wins.
- Response: next cycle `wb_valid=1`, `wb_rd=tag`, `wb_data=me_readdata`. A tag-0 response gives `wb_valid=0`.
- A response whose tag t≠0 has `busy[t]=0` sets `tag_error`. Its writeback is still produced.
- `flush` resets the read/write pointers and count and blocks enqueue and issue that cycle. It does not touch `busy`: in-flight loads still return, clear their bits and write back.
- Pointers wrap modulo `DEPTH`. Count width is clog2(DEPTH)+1. Simultaneous enqueue and issue leaves count unchanged.

## Timing
- Reset values: queue empty, `busy=0`, `wb_valid=0`, `wb_rd=0`, `wb_data=0`, `tag_error=0`. Hence `ex_ready=1` and `mem_valid=0`.
- Reset asserted mid-operation drops the queue and scoreboard immediately. Responses arriving after reset deasserts hit a non-busy tag and set `tag_error`; this is the intended flag.
- Enqueue to earliest `mem_valid`: 1 cycle (entry visible the cycle after the enqueue edge).
- Response to `wb_valid`: 1 cycle.
- A stalled load reissues the cycle after its busy bit clears.
- Throughput: one issue per cycle while `me_ready` stays high.

## Structure
- Width macros `VMSB` and `XMSB` come from the shared header `yarvi.h`.
- Add `LS_SIZE_B/H/W/D` (0..3) to `yarvi.h`.
- One sub-module, `yarvi_ls_fifo`: a parameterised synchronous FIFO with clear, storing the packed request {store, address, data, sizelg2, rd, signextend}.
- Scoreboard, hazard logic and writeback register live in the top.

## Test plan
- After reset: `ex_ready=1`, `mem_valid=0`, `busy=0`. Load rd=5 to 0x80000008 with `me_ready=1` → `mem_valid` next cycle with readtag 5, `busy[5]=1`. Response tag 5 data 0x1234 → `wb_valid`, `wb_rd=5`, `wb_data=0x1234` one cycle later, `busy[5]=0`.
- Enqueue 4 stores with `me_ready=0` → `ex_ready=0`. Raise `me_ready` → 4 consecutive issues in order, `ex_ready` high after the first pop.
- Load rd=7, then load rd=7 → second `mem_valid` stays low until the first response arrives, then issues next cycle.
- Load rd=0 → issues, `busy` unchanged. Tag-0 response → `wb_valid=0`, `tag_error=0`.
- Queue 3 entries, pulse `flush` → `mem_valid=0` and `ex_ready=1` next cycle. An earlier-issued load still returns and clears its busy bit.
- Response tag 9 with `busy=0` → `tag_error=1` and stays 1 until reset.
